// File: rtl/macro_sched_layer5_pkg.sv
// Shared types and default timing for the layer-5 macro-bank scheduler.
package macro_sched_layer5_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      CONV  = 2'd2,
      LATCH = 2'd3
   } sched_state_t;

   localparam int SETUP_CYC_DEF = 2;
   localparam int ADC_CYC_DEF   = 3;
   localparam int PASS_W        = 2;

endpackage

// File: rtl/macro_sched_layer5_pix_frame_cnt.sv
// Per-frame pixel counter with a frame-complete pulse, reusable by other layer schedulers.
// inc is the early (next-cycle) indication of a completed pixel, so the count and
// frame_done become visible on the same cycle as the scheduler's pix_done pulse.
module macro_sched_layer5_pix_frame_cnt #(
   parameter int PIX_NUM = 784,
   parameter int CNT_W   = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] pix_cnt,
   output logic             frame_done
);

   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_NUM - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             frame_done_q, frame_done_d;

   // Next count: frame sync clears, a completed pixel advances and wraps at the frame end.
   always_comb begin
      cnt_d        = cnt_q;
      frame_done_d = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         if (cnt_q == LAST_PIX) begin
            cnt_d        = '0;
            frame_done_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Counter and frame pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign pix_cnt    = cnt_q;
   assign frame_done = frame_done_q;

endmodule

// File: rtl/macro_sched_layer5.sv
// Layer-5 CIM macro-bank sequencer: runs PASS_NUM setup/convert/latch passes per
// accepted pixel, buffers one pending pixel, and counts pixels per frame.
// All outputs are registered from the next-state values so they line up with the state.
module macro_sched_layer5
   import macro_sched_layer5_pkg::*;
#(
   parameter int FM_WIDTH  = 28,
   parameter int PASS_NUM  = 4,
   parameter int SETUP_CYC = SETUP_CYC_DEF,
   parameter int ADC_CYC   = ADC_CYC_DEF,
   parameter int CNT_W     = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic              vs,
   input  logic              data_e,
   output logic              macro_e,
   output logic [PASS_W-1:0] chs_macro,
   output logic              adc,
   output logic              ps_e,
   output logic              ps_last,
   output logic              busy,
   output logic              pix_done,
   output logic              frame_done,
   output logic              overflow,
   output logic [CNT_W-1:0]  pix_cnt
);

   localparam int PIX_NUM = FM_WIDTH * FM_WIDTH;
   localparam int CYC_MAX = (SETUP_CYC > ADC_CYC) ? SETUP_CYC : ADC_CYC;
   localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

   localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASS_NUM - 1);
   localparam logic [CYC_W-1:0]  SETUP_END = CYC_W'(SETUP_CYC - 1);
   localparam logic [CYC_W-1:0]  ADC_END   = CYC_W'(ADC_CYC - 1);

   sched_state_t      state_q, state_d;
   logic [CYC_W-1:0]  cyc_q, cyc_d;
   logic [PASS_W-1:0] pass_q, pass_d;
   logic              pending_q, pending_d;
   logic              overflow_q, overflow_d;
   logic              macro_e_q, macro_e_d;
   logic              adc_q, adc_d;
   logic              ps_e_q, ps_e_d;
   logic              ps_last_q, ps_last_d;
   logic              busy_q, busy_d;
   logic              pix_done_q, pix_done_d;
   logic [PASS_W-1:0] chs_macro_q, chs_macro_d;
   logic              last_latch;
   logic              abort_busy;

   // Next-state, pending-buffer and registered-output decode for the pass sequencer.
   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      pass_d      = pass_q;
      pending_d   = pending_q;
      overflow_d  = overflow_q;
      last_latch  = (state_q == LATCH) && (pass_q == LAST_PASS);
      abort_busy  = vs && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (data_e && mode && !vs) begin
               state_d = SETUP;
               cyc_d   = '0;
               pass_d  = '0;
            end
         end
         SETUP: begin
            if (cyc_q == SETUP_END) begin
               state_d = CONV;
               cyc_d   = '0;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         CONV: begin
            if (cyc_q == ADC_END) begin
               state_d = LATCH;
               cyc_d   = '0;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         LATCH: begin
            cyc_d = '0;
            if (pass_q != LAST_PASS) begin
               state_d = SETUP;
               pass_d  = pass_q + PASS_W'(1);
            end else if (pending_q || data_e) begin
               // Start the next pixel straight away; a new pixel arriving now refills the slot.
               state_d   = SETUP;
               pass_d    = '0;
               pending_d = pending_q && data_e;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cyc_d   = '0;
            pass_d  = '0;
         end
      endcase

      // A pixel arriving mid-pixel waits in the single pending slot, or is lost.
      if (data_e && (state_q != IDLE) && !last_latch) begin
         if (!pending_q) begin
            pending_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end

      // Parameter reload: abort, ignore data_e, keep overflow.
      if (!mode) begin
         state_d    = IDLE;
         cyc_d      = '0;
         pass_d     = '0;
         pending_d  = 1'b0;
         overflow_d = overflow_q;
      end

      // Frame sync wins over reload for the clears.
      if (vs) begin
         state_d    = IDLE;
         cyc_d      = '0;
         pass_d     = '0;
         pending_d  = 1'b0;
         overflow_d = 1'b0;
      end

      busy_d     = (state_d != IDLE);
      macro_e_d  = busy_d;
      adc_d      = (state_d == CONV);
      ps_e_d     = (state_d == LATCH);
      ps_last_d  = ps_e_d && (pass_d == LAST_PASS);
      pix_done_d = ps_last_d;

      chs_macro_d = chs_macro_q;
      if (state_d != IDLE) begin
         chs_macro_d = pass_d;
      end else if (!mode || abort_busy) begin
         chs_macro_d = '0;
      end
   end

   // Scheduler state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cyc_q       <= '0;
         pass_q      <= '0;
         pending_q   <= 1'b0;
         overflow_q  <= 1'b0;
         macro_e_q   <= 1'b0;
         adc_q       <= 1'b0;
         ps_e_q      <= 1'b0;
         ps_last_q   <= 1'b0;
         busy_q      <= 1'b0;
         pix_done_q  <= 1'b0;
         chs_macro_q <= '0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         pass_q      <= pass_d;
         pending_q   <= pending_d;
         overflow_q  <= overflow_d;
         macro_e_q   <= macro_e_d;
         adc_q       <= adc_d;
         ps_e_q      <= ps_e_d;
         ps_last_q   <= ps_last_d;
         busy_q      <= busy_d;
         pix_done_q  <= pix_done_d;
         chs_macro_q <= chs_macro_d;
      end
   end

   macro_sched_layer5_pix_frame_cnt #(
      .PIX_NUM (PIX_NUM),
      .CNT_W   (CNT_W)
   ) u_pix_frame_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr        (vs),
      .inc        (pix_done_d),
      .pix_cnt    (pix_cnt),
      .frame_done (frame_done)
   );

   assign macro_e   = macro_e_q;
   assign chs_macro = chs_macro_q;
   assign adc       = adc_q;
   assign ps_e      = ps_e_q;
   assign ps_last   = ps_last_q;
   assign busy      = busy_q;
   assign pix_done  = pix_done_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_macro_sched_layer5.sv
// Directed bench for macro_sched_layer5 (FM_WIDTH=2 so a frame is 4 pixels).
module tb_macro_sched_layer5;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode;
   logic       vs;
   logic       data_e;
   logic       macro_e;
   logic [1:0] chs_macro;
   logic       adc;
   logic       ps_e;
   logic       ps_last;
   logic       busy;
   logic       pix_done;
   logic       frame_done;
   logic       overflow;
   logic [9:0] pix_cnt;

   int tests = 0;
   int fails = 0;
   int pd_cnt = 0;
   int pd0;

   logic [7:0] obs;
   assign obs = {busy, macro_e, adc, ps_e, ps_last, pix_done, chs_macro};

   macro_sched_layer5 #(
      .FM_WIDTH  (2),
      .PASS_NUM  (4),
      .SETUP_CYC (2),
      .ADC_CYC   (3),
      .CNT_W     (10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .vs         (vs),
      .data_e     (data_e),
      .macro_e    (macro_e),
      .chs_macro  (chs_macro),
      .adc        (adc),
      .ps_e       (ps_e),
      .ps_last    (ps_last),
      .busy       (busy),
      .pix_done   (pix_done),
      .frame_done (frame_done),
      .overflow   (overflow),
      .pix_cnt    (pix_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pix_done === 1'b1) pd_cnt <= pd_cnt + 1;
   end

   // Expected {busy, macro_e, adc, ps_e, ps_last, pix_done, chs} k cycles after data_e.
   // Pass = 6 cycles: 2 setup, 3 adc, 1 latch; 4 passes per pixel.
   function automatic logic [7:0] model(input int k);
      int p;
      int ph;
      p  = (k - 1) / 6;
      ph = (k - 1) % 6;
      model = {1'b1, 1'b1, (ph >= 2 && ph <= 4), (ph == 5),
               (ph == 5 && p == 3), (ph == 5 && p == 3), 2'(p)};
   endfunction

   // Two back-to-back pixels, then idle with chs left at the last pass.
   function automatic logic [7:0] model2(input int k);
      if (k <= 24)      model2 = model(k);
      else if (k <= 48) model2 = model(k - 24);
      else              model2 = 8'h03;
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic run_pixel(input string tag, input int exp_cnt, input int exp_fd);
      data_e = 1'b1;
      step();
      data_e = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         chk($sformatf("%s k=%0d", tag, k), 32'(obs), 32'(model(k)));
         if (k == 24) begin
            chk({tag, " pix_cnt"}, 32'(pix_cnt), 32'(exp_cnt));
            chk({tag, " frame_done"}, 32'(frame_done), 32'(exp_fd));
         end
         step();
      end
      chk({tag, " idle"}, 32'(obs), 32'h03);
      chk({tag, " frame_done off"}, 32'(frame_done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst    = 1'b1;
      mode   = 1'b1;
      vs     = 1'b0;
      data_e = 1'b0;
      #12;
      chk("reset outs", 32'(obs), 32'd0);
      chk("reset pix_cnt", 32'(pix_cnt), 32'd0);
      chk("reset overflow", 32'(overflow), 32'd0);
      chk("reset frame_done", 32'(frame_done), 32'd0);
      rst = 1'b0;
      step();
      step();

      // Single pixel.
      run_pixel("single", 1, 0);
      step();

      // Back-to-back: pending at k=2, dropped at k=4, second pixel at k=25.
      pd0    = pd_cnt;
      data_e = 1'b1;
      step();
      data_e = 1'b0;
      for (int k = 1; k <= 49; k++) begin
         chk($sformatf("b2b k=%0d", k), 32'(obs), 32'(model2(k)));
         if (k == 5) chk("b2b overflow", 32'(overflow), 32'd1);
         data_e = (k == 2 || k == 4);
         step();
      end
      chk("b2b pix_done count", 32'(pd_cnt - pd0), 32'd2);
      chk("b2b pix_cnt", 32'(pix_cnt), 32'd3);

      // vs while idle clears count and overflow.
      vs = 1'b1;
      step();
      vs = 1'b0;
      chk("vs idle overflow", 32'(overflow), 32'd0);
      chk("vs idle pix_cnt", 32'(pix_cnt), 32'd0);
      chk("vs idle busy", 32'(busy), 32'd0);

      // data_e during the last-pass latch chains directly.
      data_e = 1'b1;
      step();
      data_e = 1'b0;
      for (int k = 1; k <= 49; k++) begin
         chk($sformatf("chain k=%0d", k), 32'(obs), 32'(model2(k)));
         if (k == 25) chk("chain overflow", 32'(overflow), 32'd0);
         data_e = (k == 24);
         step();
      end
      chk("chain overflow end", 32'(overflow), 32'd0);
      chk("chain pix_cnt", 32'(pix_cnt), 32'd2);

      // Frame wrap with a 4-pixel frame.
      vs = 1'b1;
      step();
      vs = 1'b0;
      chk("wrap start pix_cnt", 32'(pix_cnt), 32'd0);
      run_pixel("wrap1", 1, 0);
      step();
      run_pixel("wrap2", 2, 0);
      step();
      run_pixel("wrap3", 3, 0);
      step();
      run_pixel("wrap4", 0, 1);
      step();

      // mode=0 mid-pixel aborts; data_e with mode=0 is ignored; overflow kept.
      pd0    = pd_cnt;
      data_e = 1'b1;
      step();
      data_e = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (k == 10) chk("mode pre-abort", 32'(obs), 32'(model(10)));
         data_e = (k == 2 || k == 4);
         step();
      end
      // Now at k=11 having sampled data_e from k=10 cycle? no: k=10 stepped to k=11.
      chk("mode overflow set", 32'(overflow), 32'd1);
      mode   = 1'b0;
      data_e = 1'b1;
      step();
      data_e = 1'b0;
      chk("mode abort outs", 32'(obs), 32'd0);
      chk("mode abort overflow kept", 32'(overflow), 32'd1);
      chk("mode abort pix_cnt kept", 32'(pix_cnt), 32'd0);
      mode = 1'b1;
      for (int k = 0; k < 30; k++) step();
      chk("mode no pending restart", 32'(obs), 32'd0);
      chk("mode no pix_done", 32'(pd_cnt - pd0), 32'd0);

      // vs while busy: abort, clear count/overflow/pending.
      run_pixel("pre-vs", 1, 0);
      step();
      pd0    = pd_cnt;
      data_e = 1'b1;
      step();
      data_e = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         data_e = (k == 2);
         step();
      end
      vs     = 1'b1;
      data_e = 1'b1;
      step();
      vs     = 1'b0;
      data_e = 1'b0;
      chk("vs busy outs", 32'(obs), 32'd0);
      chk("vs busy pix_cnt", 32'(pix_cnt), 32'd0);
      chk("vs busy overflow", 32'(overflow), 32'd0);
      for (int k = 0; k < 30; k++) step();
      chk("vs busy pending cleared", 32'(busy), 32'd0);
      chk("vs busy no pix_done", 32'(pd_cnt - pd0), 32'd0);

      // Async reset mid-CONV.
      data_e = 1'b1;
      step();
      data_e = 1'b1;
      step();
      data_e = 1'b1;
      step();
      data_e = 1'b0;
      chk("rst pre conv", 32'(obs), 32'(model(3)));
      chk("rst pre overflow", 32'(overflow), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst outs", 32'(obs), 32'd0);
      chk("async rst overflow", 32'(overflow), 32'd0);
      chk("async rst pix_cnt", 32'(pix_cnt), 32'd0);
      #2;
      rst = 1'b0;
      step();
      run_pixel("post-rst", 1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
